// File: rtl/buffer_writer_pkg.sv
// Shared types and helpers for the circular-buffer writer: FSM states,
// pointer width and a wrap-around increment.
package buffer_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Guard keeps a one-entry buffer from producing a zero-width pointer.
  function automatic int ptr_width(input int columns);
    return (columns > 1) ? $clog2(columns) : 1;
  endfunction

  function automatic int unsigned inc_mod(input int unsigned value, input int unsigned columns);
    int unsigned sum;
    sum = value + 1;
    if (sum >= columns) sum = sum - columns;
    return sum;
  endfunction

endpackage

// File: rtl/buffer_writer_full_check.sv
// Full detection: the buffer is full when advancing the next write slot
// would collide with the reader pointer (one slot always stays empty).
module full_check
  import buffer_writer_pkg::*;
#(
  parameter int COLUMNS = 32
) (
  input  logic [$clog2(COLUMNS)-1:0] slot,
  input  logic [$clog2(COLUMNS)-1:0] read_ptr,
  output logic                       full
);

  localparam int PW = ptr_width(COLUMNS);
  localparam logic [PW:0] COLS = (PW+1)'(COLUMNS);

  logic [PW:0] slot_sum;
  logic [PW:0] slot_next;

  always_comb begin
    slot_sum  = {1'b0, slot} + (PW+1)'(1);
    slot_next = (slot_sum >= COLS) ? (slot_sum - COLS) : slot_sum;
    full      = (slot_next == {1'b0, read_ptr});
  end

endmodule

// File: rtl/buffer_writer.sv
// Writer side of a circular buffer: accepts upstream entries, issues
// registered write strobes and tracks the committed write pointer.
module buffer_writer
  import buffer_writer_pkg::*;
#(
  parameter int COLUMNS    = 32,
  parameter int DATA_WIDTH = 16,
  parameter int PAR_READ   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  input  logic [$clog2(COLUMNS)-1:0]  read_ptr,
  output logic                        wr_en,
  output logic [$clog2(COLUMNS)-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]       wr_data,
  output logic [$clog2(COLUMNS)-1:0]  write_ptr,
  output logic                        full,
  output logic [$clog2(COLUMNS):0]    level,
  output logic                        avail
);

  localparam int PW = ptr_width(COLUMNS);
  localparam logic [PW:0] COLS = (PW+1)'(COLUMNS);
  localparam logic [PW:0] PAR  = (PW+1)'(PAR_READ);

  state_t        state;
  logic [PW:0]   slot_sum;
  logic [PW-1:0] slot;
  logic          accept;

  // The next free slot skips past an entry still waiting to be committed.
  always_comb begin
    slot_sum = {1'b0, write_ptr} + {{PW{1'b0}}, wr_en};
    slot     = (slot_sum >= COLS) ? PW'(slot_sum - COLS) : PW'(slot_sum);
  end

  full_check #(
    .COLUMNS (COLUMNS)
  ) u_full_check (
    .slot     (slot),
    .read_ptr (read_ptr),
    .full     (full)
  );

  assign in_ready = (state == RUN) && !clear && !full;
  assign accept   = in_valid && in_ready;

  // Occupancy counts committed entries only.
  always_comb begin
    if (write_ptr >= read_ptr)
      level = {1'b0, write_ptr} - {1'b0, read_ptr};
    else
      level = {1'b0, write_ptr} + COLS - {1'b0, read_ptr};
  end

  assign avail = (level >= PAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      write_ptr <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= slot;
        wr_data <= in_data;
      end
      if (wr_en)
        write_ptr <= PW'(inc_mod(32'(write_ptr), COLUMNS));

      // A flush resynchronises the writer to the reader, emptying the buffer.
      case (state)
        IDLE: begin
          if (clear)
            write_ptr <= read_ptr;
          else if (enable)
            state <= RUN;
        end
        RUN: begin
          if (clear)
            state <= DRAIN;
        end
        DRAIN: begin
          if (!wr_en) begin
            state     <= IDLE;
            write_ptr <= read_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_writer.sv
// Directed testbench for buffer_writer with COLUMNS=8, DATA_WIDTH=8, PAR_READ=4.
module tb_buffer_writer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [2:0] read_ptr;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] write_ptr;
  logic       full;
  logic [3:0] level;
  logic       avail;

  int checks = 0;
  int errors = 0;

  buffer_writer #(
    .COLUMNS    (8),
    .DATA_WIDTH (8),
    .PAR_READ   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .read_ptr  (read_ptr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .write_ptr (write_ptr),
    .full      (full),
    .level     (level),
    .avail     (avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] rp);
    rst_n    = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    read_ptr = rp;
    step();
    rst_n = 1'b1;
  endtask

  task automatic enable_run();
    enable = 1'b1;
    step();
    enable = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3'd3);
    rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %0b expected 0", wr_en); end
    checks++; if (write_ptr !== 3'd0) begin errors++; $display("[TB] FAIL reset_write_ptr: got %0d expected 0", write_ptr); end
    checks++; if (wr_addr !== 3'd0 || wr_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_wr_addr_data: got %0d/%0h expected 0/0", wr_addr, wr_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (level !== 4'd5) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 5", level); end
    read_ptr = 3'd0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    do_reset(3'd0);
    enable_run();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA1 + 8'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL seq_in_ready[%0d]: got %0b expected 1", i, in_ready); end
      step();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 3'(i) || wr_data !== 8'hA1 + 8'(i)) begin
        errors++;
        $display("[TB] FAIL seq_write[%0d]: got en=%0b addr=%0d data=%0h expected en=1 addr=%0d data=%0h",
                 i, wr_en, wr_addr, wr_data, i, 8'hA1 + 8'(i));
      end
    end
    in_valid = 1'b0;
    checks++; if (write_ptr !== 3'd2) begin errors++; $display("[TB] FAIL seq_write_ptr_early: got %0d expected 2", write_ptr); end
    step();
    checks++; if (write_ptr !== 3'd3) begin errors++; $display("[TB] FAIL seq_write_ptr: got %0d expected 3", write_ptr); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL seq_wr_en_idle: got %0b expected 0", wr_en); end
    checks++; if (level !== 4'd3 || avail !== 1'b0) begin errors++; $display("[TB] FAIL seq_level_avail: got %0d/%0b expected 3/0", level, avail); end
  endtask

  task automatic test_fill();
    int accepts;
    do_reset(3'd0);
    enable_run();
    accepts  = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'h10 + 8'(i);
      #1;
      if (in_ready) accepts++;
      step();
    end
    checks++; if (accepts !== 7) begin errors++; $display("[TB] FAIL fill_accepts: got %0d expected 7", accepts); end
    checks++; if (full !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_full: got full=%0b ready=%0b expected 1/0", full, in_ready); end
    checks++; if (level !== 4'd7 || write_ptr !== 3'd7) begin errors++; $display("[TB] FAIL fill_level: got %0d wp=%0d expected 7 wp=7", level, write_ptr); end
    checks++; if (avail !== 1'b1) begin errors++; $display("[TB] FAIL fill_avail: got %0b expected 1", avail); end
  endtask

  // Continues from the full buffer left by test_fill.
  task automatic test_back_to_back();
    int accepts;
    accepts  = 0;
    read_ptr = 3'd4;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_rise: got %0b expected 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      #1;
      if (in_ready) accepts++;
      step();
    end
    in_valid = 1'b0;
    checks++; if (accepts !== 4) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d expected 4", accepts); end
    checks++; if (full !== 1'b1 || write_ptr !== 3'd3) begin errors++; $display("[TB] FAIL b2b_full: got full=%0b wp=%0d expected 1 wp=3", full, write_ptr); end
    checks++; if (level !== 4'd7) begin errors++; $display("[TB] FAIL b2b_level: got %0d expected 7", level); end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_addr [3];
    exp_addr = '{3'd6, 3'd7, 3'd0};
    do_reset(3'd6);
    clear  = 1'b1;
    enable = 1'b1;
    step();
    clear  = 1'b0;
    enable = 1'b0;
    in_valid = 1'b1;
    #1;
    checks++; if (write_ptr !== 3'd6) begin errors++; $display("[TB] FAIL idle_clear_ptr: got %0d expected 6", write_ptr); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL clear_wins_ready: got %0b expected 0", in_ready); end
    in_valid = 1'b0;
    read_ptr = 3'd5;
    enable_run();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC0 + 8'(i);
      step();
      checks++; if (wr_addr !== exp_addr[i] || wr_en !== 1'b1) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %0d en=%0b expected %0d en=1", i, wr_addr, wr_en, exp_addr[i]); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (write_ptr !== 3'd1) begin errors++; $display("[TB] FAIL wrap_write_ptr: got %0d expected 1", write_ptr); end
    checks++; if (level !== 4'd4 || avail !== 1'b1) begin errors++; $display("[TB] FAIL wrap_level_avail: got %0d/%0b expected 4/1", level, avail); end
  endtask

  task automatic test_clear();
    do_reset(3'd0);
    enable_run();
    in_valid = 1'b1;
    in_data  = 8'h5C;
    step();
    in_data = 8'h77;
    clear   = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL clear_ready: got %0b expected 0", in_ready); end
    step();
    clear = 1'b0;
    checks++; if (wr_en !== 1'b0 || wr_data !== 8'h5C || wr_addr !== 3'd0) begin errors++; $display("[TB] FAIL clear_no_accept: got en=%0b data=%0h addr=%0d expected 0/5c/0", wr_en, wr_data, wr_addr); end
    checks++; if (write_ptr !== 3'd1) begin errors++; $display("[TB] FAIL clear_pending_commit: got %0d expected 1", write_ptr); end
    step();
    checks++; if (write_ptr !== 3'd0 || level !== 4'd0) begin errors++; $display("[TB] FAIL clear_flush: got wp=%0d level=%0d expected 0/0", write_ptr, level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL clear_idle_ready: got %0b expected 0", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL clear_idle_wr_en: got %0b expected 0", wr_en); end
  endtask

  task automatic test_reset_mid();
    do_reset(3'd0);
    enable_run();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h30 + 8'(i);
      step();
    end
    checks++; if (wr_en !== 1'b1 || write_ptr !== 3'd2) begin errors++; $display("[TB] FAIL mid_pre: got en=%0b wp=%0d expected 1/2", wr_en, write_ptr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || write_ptr !== 3'd0) begin errors++; $display("[TB] FAIL mid_async: got en=%0b wp=%0d expected 0/0", wr_en, write_ptr); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_ready: got %0b expected 0", in_ready); end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_write[%0d]: got %0b expected 0", i, wr_en); end
    end
    enable_run();
    in_data = 8'h99;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_restart_ready: got %0b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (wr_en !== 1'b1 || wr_addr !== 3'd0 || wr_data !== 8'h99) begin errors++; $display("[TB] FAIL mid_restart_write: got en=%0b addr=%0d data=%0h expected 1/0/99", wr_en, wr_addr, wr_data); end
    step();
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    read_ptr = 3'd0;
    test_reset();
    test_sequence();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
